n_bit_1_to_m_stream_demux: RTL and testbench
============================================

// Module: n_bit_1_to_m_stream_demux
// PURPOSE
//  Registered, parametrised 1-to-M demultiplexer with valid/ready flow control.
//  One N-bit input stream is routed to one of M output channels by a select field.
//  A broadcast mode sends the word to every channel at once.
//  Each channel has a one-entry holding slot, so one stalled consumer never blocks traffic to the others.
//  Sits between a single producer and M independent consumers.
// PARAMETERS
//  N      8  data width in bits (>=1)
//  M      4  number of output channels (2..64, need not be a power of two)
//  SEL_W  $clog2(M)  select width; derived, do not override
// PORTS
//  clk        in   1        clock; all state changes on rising edge
//  rst        in   1        reset: asynchronous, active-high
//  in_data    in   N        input word
//  in_sel     in   SEL_W    destination channel index
//  in_bcast   in   1        1 = broadcast to all channels; in_sel ignored
//  in_valid   in   1        input word present
//  in_ready   out  1        block accepts word this cycle
//  out_data   out  M*N      channel k data at [k*N +: N]
//  out_valid  out  M        channel k slot holds a word
//  out_ready  in   M        channel k consumer takes word
//  err        out  1        sticky: a word arrived with in_sel >= M
// BEHAVIOUR
//  - Reset, asynchronous: all slots empty; out_valid=0; out_data=0; err=0. in_ready is combinational and reads 1 while in reset.
//  - Transfers: input transfer = in_valid & in_ready; channel k transfer = out_valid[k] & out_ready[k].
//  - Slot k has space = ~out_valid[k] | out_ready[k]. Same-cycle drain and refill is allowed, giving full throughput.
//  - in_ready, combinational:
//      in_bcast=1: AND of space over all k.
//      in_bcast=0, in_sel<M: space[in_sel].
//      in_sel>=M: 1.
//  - Latency: word accepted on edge t appears on out_valid/out_data after edge t. One cycle, no combinational in->out path.
//  - Unicast accept: slot in_sel loads in_data and sets valid. Other slots are unaffected except by their own drains.
//  - Broadcast accept: every slot loads in_data and sets valid in the same edge. Partial broadcast never happens.
//  - Invalid select (in_sel>=M, in_bcast=0): the word is accepted and dropped, and err sets to 1.
//      err stays 1 until rst.
//      With M a power of two this case cannot occur and err stays 0.
//  - Empty-slot data: out_data slice k is all-zero whenever out_valid[k]=0. Inactive outputs are zeros, not stale data.
//  - Drain without refill: slot clears valid, and its data slice goes to zero on the same edge.
//  - Stability: while out_valid[k]=1 and out_ready[k]=0, slice k holds its value and valid stays high.
//  - No state machine beyond per-slot valid bits. All selection logic is fully assigned in every branch, so no latches.
//  - Reset mid-operation discards all held words immediately, with no drain.
// STRUCTURE
//  - Package demux_pkg:
//      function sel_width(M) returning $clog2(M), min 1
//      localparam DATA_ZERO pattern helper
//      enum-free; there are no FSM typedefs
//  - Sub-module demux_chan_slot #(N):
//      one-entry valid/data register with load, take, and zero-when-empty output
//      instantiated M times via generate
//  - Top level holds: select decode (one-hot of M, plus broadcast OR), in_ready reduction, err flag.
// TESTING (N=8, M=4 unless noted)
//  1. Reset: assert rst mid-traffic -> out_valid=0000, out_data=0, err=0 at once; after release in_ready=1.
//  2. Unicast: in_data=A5, sel=2, valid 1 cycle, out_ready=1111 -> next cycle out_valid=0100, slice2=A5, other slices 00. The cycle after, all zero.
//  3. Backpressure isolation: out_ready[1]=0; send 11 then 22 to sel=1 -> 11 held, in_ready=0 for sel=1; 33 to sel=3 is still accepted. Raising out_ready[1] delivers 11 then 22 in order.
//  4. Broadcast: bcast=1, data=3C -> all out_valid=1111, each slice 3C.
//     With slot 0 full and stalled, in_ready=0 and no slot loads until slot 0 drains.
//  5. Invalid select, M=5: sel=6 -> in_ready=1, word dropped, out_valid unchanged, err=1 and stays 1.
//  6. Streaming: sel cycling 0..3 back-to-back with out_ready=1111 -> one word per cycle, in_ready constantly 1, no loss, no duplication.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared helpers for the 1-to-M stream demux.
// Select-width derivation and the empty-slot data pattern.
package demux_pkg;

  // Bit pattern that fills an empty slot; replicated to N bits.
  localparam logic DATA_ZERO = 1'b0;

  // Select width for M channels; a 1-bit field is kept even for M<=1.
  function automatic int sel_width(input int m);
    if (m <= 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// One-entry holding slot for a single demux output channel.
// Ports: clk, rst, i_load/i_data (fill), i_take (drain), o_valid/o_data.
module demux_chan_slot
  import demux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [N-1:0] i_data,
  input  logic         i_take,
  output logic         o_valid,
  output logic [N-1:0] o_data
);

  logic         r_valid;
  logic [N-1:0] r_data;

  // Load wins over take: a same-cycle drain and refill keeps the slot full.
  // Data is cleared on drain so an empty slot always shows zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {N{DATA_ZERO}};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_take) begin
      r_valid <= 1'b0;
      r_data  <= {N{DATA_ZERO}};
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/n_bit_1_to_m_stream_demux.sv
// Registered 1-to-M valid/ready demux with broadcast and sticky bad-select flag.
// Ports: in_* producer side, out_* M consumer channels, err sticky flag.
module n_bit_1_to_m_stream_demux
  import demux_pkg::*;
#(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int SEL_W = sel_width(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [M*N-1:0]   out_data,
  output logic [M-1:0]     out_valid,
  input  logic [M-1:0]     out_ready,
  output logic             err
);

  logic [M-1:0] w_hit;
  logic [M-1:0] w_space;
  logic [M-1:0] w_load;
  logic         w_sel_ok;
  logic         w_acc;
  logic         r_err;

  for (genvar k = 0; k < M; k++) begin : g_chan
    assign w_hit[k]   = (in_sel == SEL_W'(k));
    assign w_space[k] = ~out_valid[k] | out_ready[k];
    assign w_load[k]  = w_acc & (in_bcast | w_hit[k]);

    demux_chan_slot #(
      .N (N)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_take  (out_ready[k]),
      .o_valid (out_valid[k]),
      .o_data  (out_data[k*N +: N])
    );
  end

  // No hit means in_sel >= M; such words are swallowed.
  assign w_sel_ok = |w_hit;

  // Broadcast waits for every slot so a word is never half-delivered.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &w_space;
    end else if (w_sel_ok) begin
      in_ready = |(w_hit & w_space);
    end
  end

  assign w_acc = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_acc && !in_bcast && !w_sel_ok) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_n_bit_1_to_m_stream_demux.sv
// Scoreboard bench for the stream demux.
// Checks an M=4 instance and an M=5 instance for the bad-select case.
module tb_n_bit_1_to_m_stream_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast, in_valid, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid, out_ready;
  logic        err;

  logic [7:0]  d5_data;
  logic [2:0]  d5_sel;
  logic        d5_bcast, d5_valid, d5_ready;
  logic [39:0] d5_odata;
  logic [4:0]  d5_ovalid, d5_oready;
  logic        d5_err;

  n_bit_1_to_m_stream_demux #(.N(8), .M(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .err(err)
  );

  n_bit_1_to_m_stream_demux #(.N(8), .M(5)) dut5 (
    .clk(clk), .rst(rst),
    .in_data(d5_data), .in_sel(d5_sel),
    .in_bcast(d5_bcast), .in_valid(d5_valid),
    .in_ready(d5_ready), .out_data(d5_odata),
    .out_valid(d5_ovalid), .out_ready(d5_oready),
    .err(d5_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;
  logic [7:0] sbq [4][$];

  always @(posedge clk) n_cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change only at posedge+1, so negedge values equal edge values.
  always @(negedge clk) begin
    logic [3:0] sp;
    logic       er;
    if (rst) begin
      for (int k = 0; k < 4; k++) sbq[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        sp[k] = (sbq[k].size() == 0) || out_ready[k];
        chk($sformatf("vld%0d", k), 64'(out_valid[k]),
            64'(sbq[k].size() != 0));
        if (!out_valid[k])
          chk($sformatf("zero%0d", k), 64'(out_data[k*8 +: 8]), 64'h0);
      end
      er = in_bcast ? &sp : sp[in_sel];
      chk("in_ready", 64'(in_ready), 64'(er));
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k] && sbq[k].size() != 0)
          chk($sformatf("sb_ch%0d", k), 64'(out_data[k*8 +: 8]),
              64'(sbq[k].pop_front()));
      end
      if (in_valid && in_ready) begin
        if (in_bcast) begin
          for (int k = 0; k < 4; k++) sbq[k].push_back(in_data);
        end else begin
          sbq[in_sel].push_back(in_data);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] s,
                      input logic b);
    int t;
    t = 0;
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0;
    out_ready = 4'b1111;
    d5_data = '0; d5_sel = '0; d5_bcast = 1'b0; d5_valid = 1'b0;
    d5_oready = 5'b11111;
    repeat (2) tick();
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    // unicast
    send(8'hA5, 2'd2, 1'b0);
    @(negedge clk);
    chk("uni_valid", 64'(out_valid), 64'h4);
    chk("uni_data", 64'(out_data), 64'h00A50000);
    @(negedge clk);
    chk("uni_valid2", 64'(out_valid), 64'h0);
    chk("uni_data2", 64'(out_data), 64'h0);
    tick();

    // backpressure isolation on channel 1
    out_ready = 4'b1101;
    send(8'h11, 2'd1, 1'b0);
    in_data = 8'h22; in_sel = 2'd1; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready", 64'(in_ready), 64'd0);
    tick();
    send(8'h33, 2'd3, 1'b0);
    @(negedge clk);
    chk("bp_hold", 64'(out_data[15:8]), 64'h11);
    chk("bp_hvld", 64'(out_valid[1]), 64'd1);
    tick();
    out_ready = 4'b1111;
    send(8'h22, 2'd1, 1'b0);
    repeat (2) tick();

    // broadcast, then broadcast blocked by stalled slot 0
    send(8'h3C, 2'd0, 1'b1);
    out_ready = 4'b1110;
    @(negedge clk);
    chk("bc_valid", 64'(out_valid), 64'hF);
    chk("bc_data", 64'(out_data), 64'h3C3C3C3C);
    tick();
    in_data = 8'h55; in_bcast = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("bc_blk_rdy", 64'(in_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("bc_blk_rdy2", 64'(in_ready), 64'd0);
    chk("bc_blk_vld", 64'(out_valid), 64'h1);
    chk("bc_blk_dat", 64'(out_data), 64'h0000003C);
    tick();
    out_ready = 4'b1111;
    @(negedge clk);
    chk("bc_go_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    @(negedge clk);
    chk("bc2_valid", 64'(out_valid), 64'hF);
    chk("bc2_data", 64'(out_data), 64'h55555555);
    tick();

    // back-to-back streaming
    c0 = n_cyc;
    for (int i = 0; i < 16; i++)
      send(8'(8'h80 + i), 2'(i % 4), 1'b0);
    chk("stream_cyc", 64'(n_cyc - c0), 64'd16);
    repeat (3) tick();
    for (int k = 0; k < 4; k++)
      chk($sformatf("sb_empty%0d", k), 64'(sbq[k].size()), 64'd0);
    chk("err4", 64'(err), 64'd0);

    // bad select on the M=5 instance
    d5_oready = 5'b00000;
    d5_data = 8'h77; d5_sel = 3'd4; d5_valid = 1'b1;
    tick();
    d5_data = 8'h99; d5_sel = 3'd6;
    @(negedge clk);
    chk("m5_ready", 64'(d5_ready), 64'd1);
    chk("m5_err0", 64'(d5_err), 64'd0);
    tick();
    d5_valid = 1'b0;
    @(negedge clk);
    chk("m5_err", 64'(d5_err), 64'd1);
    chk("m5_valid", 64'(d5_ovalid), 64'h10);
    chk("m5_data", 64'(d5_odata), 64'h7700000000);
    repeat (3) tick();
    chk("m5_sticky", 64'(d5_err), 64'd1);

    // reset mid-traffic
    out_ready = 4'b0000;
    send(8'hE1, 2'd0, 1'b0);
    in_data = 8'hE2; in_sel = 2'd3; in_valid = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_valid", 64'(out_valid), 64'h0);
    chk("mr_data", 64'(out_data), 64'h0);
    chk("mr_err5", 64'(d5_err), 64'd0);
    chk("mr_v5", 64'(d5_ovalid), 64'h0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 4'b1111;
    #1;
    chk("mr_ready", 64'(in_ready), 64'd1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
